// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD sector writer (and the matching sector reader):
//   - sd_state_t        : transaction state encoding
//   - SD_SECTOR_BYTES   : bytes per SD block
//   - SD_TIMEOUT_CYCLES : default wait limit on the controller, 1 s at 5 MHz
// -----------------------------------------------------------------------------
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_PREFETCH   = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_STREAM     = 3'd4,
    ST_WAIT_DONE  = 3'd5
  } sd_state_t;

  localparam int SD_SECTOR_BYTES   = 512;
  localparam int SD_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/sd_sector_writer.sv
// -----------------------------------------------------------------------------
// sd_sector_writer
// Streams one sector from a caller-owned synchronous RAM into sd_controller.
//
// Ports
//   clk_spi         in   SPI-domain clock, all logic on its rising edge
//   reset_n         in   asynchronous active-low reset
//   start           in   one-cycle request to write a sector
//   sector[31:0]    in   target block address, sampled with start
//   busy            out  high from accepted start until done
//   done            out  one-cycle end-of-transaction pulse
//   error           out  one-cycle pulse with done when a wait timed out
//   buf_addr[8:0]   out  read address into the sector buffer
//   buf_data[7:0]   in   buffer byte, valid one cycle after buf_addr
//   sdc_address     out  block address to sd_controller
//   sdc_ready       in   sd_controller idle/ready
//   sdc_write       out  one-cycle write command strobe
//   sdc_write_data  out  byte presented to sd_controller
//   sdc_write_ready in   sd_controller ready_for_next_byte
// -----------------------------------------------------------------------------
module sd_sector_writer
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT_CYCLES,
  parameter int SECTOR_BYTES   = SD_SECTOR_BYTES
) (
  input  logic        clk_spi,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] sector,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  buf_addr,
  input  logic [7:0]  buf_data,
  output logic [31:0] sdc_address,
  input  logic        sdc_ready,
  output logic        sdc_write,
  output logic [7:0]  sdc_write_data,
  input  logic        sdc_write_ready
);

  sd_state_t   state_r, state_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic [8:0]  buf_addr_r, buf_addr_s;
  logic [31:0] sdc_address_r, sdc_address_s;
  logic        sdc_write_r, sdc_write_s;
  logic [7:0]  wdata_r, wdata_s;
  logic [9:0]  index_r, index_s;
  logic [31:0] tcnt_r, tcnt_s;
  logic        wr_prev_r;
  // Two-stage refill pipeline: address issued -> RAM samples -> byte loaded.
  logic        fill1_r, fill1_s;
  logic        fill2_r, fill2_s;

  logic        wr_edge_s;
  logic [31:0] tcnt_inc_s;
  logic        timeout_s;

  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign buf_addr       = buf_addr_r;
  assign sdc_address    = sdc_address_r;
  assign sdc_write      = sdc_write_r;
  assign sdc_write_data = wdata_r;

  // Register every piece of state; reset forces everything idle at once.
  always_ff @(posedge clk_spi or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      buf_addr_r    <= 9'd0;
      sdc_address_r <= 32'd0;
      sdc_write_r   <= 1'b0;
      wdata_r       <= 8'd0;
      index_r       <= 10'd0;
      tcnt_r        <= 32'd0;
      wr_prev_r     <= 1'b0;
      fill1_r       <= 1'b0;
      fill2_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      error_r       <= error_s;
      buf_addr_r    <= buf_addr_s;
      sdc_address_r <= sdc_address_s;
      sdc_write_r   <= sdc_write_s;
      wdata_r       <= wdata_s;
      index_r       <= index_s;
      tcnt_r        <= tcnt_s;
      wr_prev_r     <= sdc_write_ready;
      fill1_r       <= fill1_s;
      fill2_r       <= fill2_s;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_s       = state_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    error_s       = 1'b0;
    buf_addr_s    = buf_addr_r;
    sdc_address_s = sdc_address_r;
    sdc_write_s   = 1'b0;
    wdata_s       = wdata_r;
    index_s       = index_r;
    tcnt_s        = tcnt_r;
    fill1_s       = 1'b0;
    fill2_s       = fill1_r;

    // Only a low-to-high transition counts, so a long ready level is one byte.
    wr_edge_s  = sdc_write_ready & ~wr_prev_r;
    tcnt_inc_s = tcnt_r + 32'd1;
    timeout_s  = (tcnt_inc_s >= 32'(TIMEOUT_CYCLES));

    // RAM output now reflects the address issued two cycles ago.
    if (fill2_r) begin
      wdata_s = buf_data;
    end else begin
      wdata_s = wdata_r;
    end

    case (state_r)
      ST_IDLE: begin
        // done_r high means this is the done cycle: a start here is dropped.
        if (start && !done_r) begin
          sdc_address_s = sector;
          index_s       = 10'd0;
          tcnt_s        = 32'd0;
          busy_s        = 1'b1;
          // Point the RAM at byte 0 early so its output is settled by PREFETCH
          // even when the previous sector left buf_addr at the last byte.
          buf_addr_s    = 9'd0;
          state_s       = ST_WAIT_READY;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT_READY: begin
        if (sdc_ready) begin
          buf_addr_s = 9'd0;
          state_s    = ST_PREFETCH;
        end else if (timeout_s) begin
          done_s      = 1'b1;
          error_s     = 1'b1;
          busy_s      = 1'b0;
          sdc_write_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          tcnt_s = tcnt_inc_s;
        end
      end

      ST_PREFETCH: begin
        wdata_s     = buf_data;
        sdc_write_s = 1'b1;
        state_s     = ST_ISSUE;
      end

      ST_ISSUE: begin
        state_s = ST_STREAM;
      end

      ST_STREAM: begin
        if (wr_edge_s) begin
          index_s = index_r + 10'd1;
          if (index_r == 10'(SECTOR_BYTES - 1)) begin
            // Last byte taken: leave buf_addr on it rather than wrap to 0.
            tcnt_s  = 32'd0;
            state_s = ST_WAIT_DONE;
          end else begin
            buf_addr_s = index_r[8:0] + 9'd1;
            fill1_s    = 1'b1;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end

      ST_WAIT_DONE: begin
        if (sdc_ready) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else if (timeout_s) begin
          done_s      = 1'b1;
          error_s     = 1'b1;
          busy_s      = 1'b0;
          sdc_write_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          tcnt_s = tcnt_inc_s;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_writer
// Directed bench: synchronous buffer RAM holding byte i = i[7:0], and a simple
// sd_controller model driven from tasks on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_sector_writer;
  import sd_pkg::*;

  logic        clk_spi;
  logic        reset_n;
  logic        start;
  logic [31:0] sector;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data;
  logic [31:0] sdc_address;
  logic        sdc_ready;
  logic        sdc_write;
  logic [7:0]  sdc_write_data;
  logic        sdc_write_ready;

  logic [7:0]  mem [0:511];

  int tests_run    = 0;
  int tests_failed = 0;

  sd_sector_writer #(
    .TIMEOUT_CYCLES(100),
    .SECTOR_BYTES  (512)
  ) dut (
    .clk_spi        (clk_spi),
    .reset_n        (reset_n),
    .start          (start),
    .sector         (sector),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .buf_addr       (buf_addr),
    .buf_data       (buf_data),
    .sdc_address    (sdc_address),
    .sdc_ready      (sdc_ready),
    .sdc_write      (sdc_write),
    .sdc_write_data (sdc_write_data),
    .sdc_write_ready(sdc_write_ready)
  );

  initial clk_spi = 1'b0;
  always #5 clk_spi = ~clk_spi;

  // Synchronous-read buffer RAM.
  always @(posedge clk_spi) buf_data <= mem[buf_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; returns on the falling edge after acceptance.
  task automatic start_sector(input logic [31:0] sec);
    @(negedge clk_spi);
    start  = 1'b1;
    sector = sec;
    @(negedge clk_spi);
    start  = 1'b0;
    sector = 32'h0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("addr_after_start", sdc_address, sec);
  endtask

  // Controller model for one sector. inject_kind: 0 none, 1 start while busy,
  // 2 reset pulse, both at byte inject_at. Returns on the done cycle.
  task automatic stream_sector(input int hold, input int inject_kind,
                               input int inject_at, input logic [31:0] exp_addr);
    int writes;
    int bad;
    bit seen;
    bit aborted;
    bit early_done;
    bit seen_done;
    writes = 0; bad = 0; seen = 1'b0; aborted = 1'b0;
    early_done = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (sdc_write) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_spi);
    end
    check_eq("write_strobe_seen", 32'(seen), 32'd1);
    if (seen) writes = 1;
    sdc_ready = 1'b0;
    for (int b = 0; b < SD_SECTOR_BYTES; b++) begin
      for (int i = 0; i < 20 - hold; i++) begin
        @(negedge clk_spi);
        if (sdc_write) writes++;
        if (inject_kind == 1 && b == inject_at) begin
          if (i == 0) begin
            start  = 1'b1;
            sector = 32'h55;
          end else begin
            start  = 1'b0;
            sector = 32'h0;
          end
        end
      end
      if (inject_kind == 1 && b == inject_at) begin
        check_eq("addr_after_busy_start", sdc_address, exp_addr);
        check_eq("busy_after_busy_start", 32'(busy), 32'd1);
      end
      if (sdc_write_data !== b[7:0]) bad++;
      sdc_write_ready = 1'b1;
      if (inject_kind == 2 && b == inject_at) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_error", 32'(error), 32'd0);
        check_eq("rst_mid_sdc_write", 32'(sdc_write), 32'd0);
        check_eq("rst_mid_wdata", 32'(sdc_write_data), 32'd0);
        check_eq("rst_mid_addr", sdc_address, 32'd0);
        check_eq("rst_mid_buf_addr", 32'(buf_addr), 32'd0);
        aborted = 1'b1;
        break;
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_spi);
        if (sdc_write) writes++;
      end
      sdc_write_ready = 1'b0;
    end
    if (aborted) begin
      @(negedge clk_spi);
      sdc_write_ready = 1'b0;
      sdc_ready       = 1'b1;
      @(negedge clk_spi);
      reset_n = 1'b1;
      @(negedge clk_spi);
      check_eq("busy_after_rst_release", 32'(busy), 32'd0);
    end else begin
      check_eq("stream_bytes_bad", 32'(bad), 32'd0);
      check_eq("write_pulses", 32'(writes), 32'd1);
      check_eq("buf_addr_no_wrap", 32'(buf_addr), 32'd511);
      // Extra ready edges after the last byte must be ignored.
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_spi);
          if (done) early_done = 1'b1;
        end
        sdc_write_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk_spi);
          if (done) early_done = 1'b1;
        end
        sdc_write_ready = 1'b0;
      end
      check_eq("no_early_done", 32'(early_done), 32'd0);
      check_eq("busy_in_wait_done", 32'(busy), 32'd1);
      check_eq("buf_addr_after_extra", 32'(buf_addr), 32'd511);
      check_eq("wdata_after_extra", 32'(sdc_write_data), 32'hFF);
      sdc_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk_spi);
        if (done) begin
          seen_done = 1'b1;
          break;
        end
      end
      check_eq("done_seen", 32'(seen_done), 32'd1);
      check_eq("error_on_done", 32'(error), 32'd0);
      check_eq("busy_on_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int  lat;
    bit  wr_seen;
    bit  to_seen;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    reset_n         = 1'b0;
    start           = 1'b0;
    sector          = 32'h0;
    sdc_ready       = 1'b1;
    sdc_write_ready = 1'b0;
    repeat (3) @(negedge clk_spi);
    reset_n = 1'b1;
    @(negedge clk_spi);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_sdc_write", 32'(sdc_write), 32'd0);
    check_eq("rst_addr", sdc_address, 32'd0);
    check_eq("rst_buf_addr", 32'(buf_addr), 32'd0);
    check_eq("rst_wdata", 32'(sdc_write_data), 32'd0);

    // Basic sector, one-cycle ready pulses every 20 cycles.
    start_sector(32'h2000);
    stream_sector(1, 0, 0, 32'h2000);

    // Still in the done cycle: this start is dropped, the next one is taken.
    start  = 1'b1;
    sector = 32'h3000;
    @(negedge clk_spi);
    check_eq("start_in_done_ignored", 32'(busy), 32'd0);
    @(negedge clk_spi);
    start  = 1'b0;
    sector = 32'h0;
    check_eq("start_after_done_busy", 32'(busy), 32'd1);
    check_eq("start_after_done_addr", sdc_address, 32'h3000);
    // Ready held high for 5 cycles per byte.
    stream_sector(5, 0, 0, 32'h3000);

    // Start while busy at byte 100.
    start_sector(32'h2000);
    stream_sector(1, 1, 100, 32'h2000);

    // Reset at byte 300, then a full sector again.
    start_sector(32'h2000);
    stream_sector(1, 2, 300, 32'h2000);
    start_sector(32'h2000);
    stream_sector(1, 0, 0, 32'h2000);

    // Controller never ready: timeout after 100 cycles in WAIT_READY.
    sdc_ready = 1'b0;
    start_sector(32'h4000);
    lat = 0; wr_seen = 1'b0; to_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sdc_write) wr_seen = 1'b1;
      if (done) begin
        to_seen = 1'b1;
        break;
      end
      @(negedge clk_spi);
      lat++;
    end
    check_eq("timeout_done_seen", 32'(to_seen), 32'd1);
    check_eq("timeout_latency", 32'(lat), 32'd100);
    check_eq("timeout_error", 32'(error), 32'd1);
    check_eq("timeout_busy", 32'(busy), 32'd0);
    check_eq("timeout_no_write", 32'(wr_seen), 32'd0);
    @(negedge clk_spi);
    check_eq("timeout_error_pulse", 32'(error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
